// File: rtl/reader.sv
// reader: assembles a 16-bit code word from keypad nibbles with backspace, clear and sticky error
module reader #(
  parameter logic [15:0] INIT_CODE = 16'h0000,
  parameter int          DIGITS    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_data,
  input  logic        key_back,
  input  logic        clear,
  output logic [15:0] code,
  output logic        code_ready,
  output logic [2:0]  count,
  output logic        err
);
  typedef enum logic [1:0] {EMPTY, ENTRY, FULL} state_t;
  state_t state;
  // entry state machine; state always mirrors count (0 / 1..3 / 4), back beats key, clear/rst beat both
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state      <= EMPTY;
      code       <= INIT_CODE;
      count      <= 3'd0;
      code_ready <= 1'b0;
      err        <= 1'b0;
    end else if (key_back) begin
      if (state == EMPTY) begin
        err <= 1'b1;
      end else begin
        code       <= {4'h0, code[15:4]};
        count      <= count - 3'd1;
        code_ready <= 1'b0;
        state      <= (count == 3'd1) ? EMPTY : ENTRY;
      end
    end else if (key_valid) begin
      if (state == FULL) begin
        err <= 1'b1;
      end else begin
        code       <= {code[11:0], key_data};
        count      <= count + 3'd1;
        code_ready <= (count == 3'(DIGITS - 1));
        state      <= (count == 3'(DIGITS - 1)) ? FULL : ENTRY;
      end
    end
  end
endmodule

// File: tb/tb_reader.sv
// tb_reader: table vectors, corner sequences and randomized model checking for reader
module tb_reader;
  logic        clk = 1'b0;
  logic        rst, key_valid, key_back, clear;
  logic [3:0]  key_data, key_data2;
  logic [15:0] code0, code1, code2;
  logic        rdy0, rdy1, rdy2, err0, err1, err2;
  logic [2:0]  cnt0, cnt1, cnt2;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  reader u0 (.clk(clk), .rst(rst), .key_valid(key_valid), .key_data(key_data), .key_back(key_back),
             .clear(clear), .code(code0), .code_ready(rdy0), .count(cnt0), .err(err0));
  reader #(.INIT_CODE(16'hFFFF)) u1 (.clk(clk), .rst(rst), .key_valid(key_valid), .key_data(key_data),
             .key_back(key_back), .clear(clear), .code(code1), .code_ready(rdy1), .count(cnt1), .err(err1));
  reader u2 (.clk(clk), .rst(rst), .key_valid(key_valid), .key_data(key_data2), .key_back(key_back),
             .clear(clear), .code(code2), .code_ready(rdy2), .count(cnt2), .err(err2));

  typedef struct {
    logic        r, c, v;
    logic [3:0]  d;
    logic        b;
    logic [15:0] code;
    int          cnt;
    logic        rdy, e;
  } vec_t;

  typedef struct {
    logic [15:0] code;
    int          n;
    logic        e;
  } mdl_t;

  vec_t vec[$];
  mdl_t m0, m1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, c, v, input logic [3:0] d, input logic b);
    rst = r; clear = c; key_valid = v; key_data = d; key_data2 = d; key_back = b;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic mdl_t step(input mdl_t m, input logic [15:0] init, input logic r, c, v,
                                input logic [3:0] d, input logic b);
    mdl_t s = m;
    if (r || c) begin
      s.code = init; s.n = 0; s.e = 1'b0;
    end else if (b) begin
      if (s.n == 0) s.e = 1'b1;
      else begin s.code = s.code >> 4; s.n--; end
    end else if (v) begin
      if (s.n == 4) s.e = 1'b1;
      else begin s.code = (s.code << 4) | 16'(d); s.n++; end
    end
    return s;
  endfunction

  initial begin
    drive(1, 0, 0, 0, 0);
    // r c v d b | code cnt rdy err
    vec.push_back('{1,0,0,4'h0,0, 16'h0000,0,0,0});
    vec.push_back('{0,0,1,4'h1,0, 16'h0001,1,0,0});
    vec.push_back('{0,0,1,4'h2,0, 16'h0012,2,0,0});
    vec.push_back('{0,0,1,4'h3,0, 16'h0123,3,0,0});
    vec.push_back('{0,0,1,4'h4,0, 16'h1234,4,1,0});
    vec.push_back('{0,1,0,4'h0,0, 16'h0000,0,0,0});
    vec.push_back('{0,0,1,4'hA,0, 16'h000A,1,0,0});
    vec.push_back('{0,0,1,4'hB,0, 16'h00AB,2,0,0});
    vec.push_back('{0,0,1,4'hC,0, 16'h0ABC,3,0,0});
    vec.push_back('{0,0,1,4'hD,0, 16'hABCD,4,1,0});
    vec.push_back('{0,0,1,4'h5,0, 16'hABCD,4,1,1});
    vec.push_back('{0,0,0,4'h0,0, 16'hABCD,4,1,1});
    vec.push_back('{0,1,0,4'h0,0, 16'h0000,0,0,0});
    vec.push_back('{0,0,1,4'h1,0, 16'h0001,1,0,0});
    vec.push_back('{0,0,1,4'h2,0, 16'h0012,2,0,0});
    vec.push_back('{0,0,1,4'h3,0, 16'h0123,3,0,0});
    vec.push_back('{0,0,0,4'h0,1, 16'h0012,2,0,0});
    vec.push_back('{0,0,1,4'h9,0, 16'h0129,3,0,0});
    vec.push_back('{0,0,1,4'h8,0, 16'h1298,4,1,0});
    vec.push_back('{0,0,0,4'h0,1, 16'h0129,3,0,0});
    vec.push_back('{0,1,0,4'h0,0, 16'h0000,0,0,0});
    vec.push_back('{0,0,0,4'h0,1, 16'h0000,0,0,1});
    vec.push_back('{0,1,0,4'h0,0, 16'h0000,0,0,0});
    vec.push_back('{0,0,1,4'h7,0, 16'h0007,1,0,0});
    vec.push_back('{0,0,1,4'h6,0, 16'h0076,2,0,0});
    vec.push_back('{0,0,1,4'h5,1, 16'h0007,1,0,0});
    vec.push_back('{0,1,1,4'h4,0, 16'h0000,0,0,0});
    vec.push_back('{0,0,1,4'h1,0, 16'h0001,1,0,0});
    vec.push_back('{0,0,1,4'h2,0, 16'h0012,2,0,0});
    vec.push_back('{1,0,1,4'h3,1, 16'h0000,0,0,0});
    foreach (vec[i]) begin
      drive(vec[i].r, vec[i].c, vec[i].v, vec[i].d, vec[i].b);
      cyc();
      check($sformatf("vec%0d code", i), 32'(code0), 32'(vec[i].code));
      check($sformatf("vec%0d count", i), 32'(cnt0), 32'(vec[i].cnt));
      check($sformatf("vec%0d ready", i), 32'(rdy0), 32'(vec[i].rdy));
      check($sformatf("vec%0d err", i), 32'(err0), 32'(vec[i].e));
    end

    // reset mid-entry on the FFFF instance
    drive(0, 0, 1, 4'h1, 0); cyc();
    check("ffff first", 32'(code1), 32'hFFF1);
    drive(0, 0, 1, 4'h2, 0); cyc();
    check("ffff second", 32'(code1), 32'hFF12);
    drive(1, 0, 0, 4'h0, 0); cyc();
    check("ffff rst code", 32'(code1), 32'hFFFF);
    check("ffff rst count", 32'(cnt1), 32'd0);
    check("ffff rst ready", 32'(rdy1), 32'd0);

    // identical digits, then one differing digit
    foreach (vec[i]) if (i < 4) begin
      drive(0, 0, 1, 4'(i * 4 + 3), 0); cyc();
    end
    check("same code0", 32'(code0), 32'h37BF);
    check("same equal", 32'(code0 ^ code2), 32'h0);
    drive(0, 1, 0, 0, 0); cyc();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 4'(i * 4 + 3), 0);
      if (i == 2) key_data2 = 4'h5;
      cyc();
    end
    check("diff code2", 32'(code2), 32'h375F);
    check("diff nibble", 32'(code0 ^ code2), 32'h00E0);

    // randomized run against the arithmetic model
    drive(1, 0, 0, 0, 0); cyc();
    m0 = '{16'h0000, 0, 1'b0};
    m1 = '{16'hFFFF, 0, 1'b0};
    for (int t = 0; t < 2000; t++) begin
      drive($urandom_range(63) == 0, $urandom_range(31) == 0, $urandom_range(1) == 1,
            4'($urandom_range(15)), $urandom_range(3) == 0);
      m0 = step(m0, 16'h0000, rst, clear, key_valid, key_data, key_back);
      m1 = step(m1, 16'hFFFF, rst, clear, key_valid, key_data, key_back);
      cyc();
      check("rnd code0", 32'(code0), 32'(m0.code));
      check("rnd count0", 32'(cnt0), 32'(m0.n));
      check("rnd ready0", 32'(rdy0), 32'(m0.n == 4));
      check("rnd err0", 32'(err0), 32'(m0.e));
      check("rnd code1", 32'(code1), 32'(m1.code));
      check("rnd count1", 32'(cnt1), 32'(m1.n));
      check("rnd ready1", 32'(rdy1), 32'(m1.n == 4));
      check("rnd err1", 32'(err1), 32'(m1.e));
      check("rnd code2", 32'(code2), 32'(m0.code));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reader.md
READER -- requirements
Module: reader

Interface
REQ-001 Parameter INIT_CODE, default 16'h0000: value loaded into code on reset and on clear.
REQ-002 Parameter DIGITS, default 4: nibbles needed to fill code (fixed 4; other values unsupported).
REQ-003 The block SHALL provide port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL provide port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL provide port key_valid, input, 1 bit: single-cycle strobe; key_data is valid in this cycle.
REQ-006 The block SHALL provide port key_data, input, 4 bits: entered digit/nibble.
REQ-007 The block SHALL provide port key_back, input, 1 bit: strobe to delete the last entered nibble.
REQ-008 The block SHALL provide port clear, input, 1 bit: strobe to abandon entry and reload INIT_CODE.
REQ-009 The block SHALL provide port code, output, 16 bits: assembled word, registered.
REQ-010 The block SHALL provide port code_ready, output, 1 bit: high while 4 nibbles are held.
REQ-011 The block SHALL provide port count, output, 3 bits: nibbles currently held (0..4).
REQ-012 The block SHALL provide port err, output, 1 bit: sticky overflow/underflow flag.

Function
REQ-013 States SHALL be: EMPTY (count=0), ENTRY (count 1..3) and FULL (count=4); the state SHALL be derived from or kept consistent with count.
REQ-014 On key_valid in EMPTY or ENTRY, the block SHALL set code <= {code[11:0], key_data} and count <= count+1, so the first nibble ends in code[15:12] after 4 entries.
REQ-015 When count reaches 4, the block SHALL set code_ready high in the same cycle that count shows 4, one clock after the 4th key_valid.
REQ-016 On key_valid in FULL, code and count SHALL be unchanged and err SHALL be set to 1.
REQ-017 On key_back in ENTRY or FULL, the block SHALL set code <= {4'h0, code[15:4]}, set count <= count-1 and drop code_ready.
REQ-018 On key_back in EMPTY, code and count SHALL be unchanged and err SHALL be set to 1.
REQ-019 If key_valid and key_back are high together, key_back SHALL win and key_valid SHALL be ignored without setting err.
REQ-020 On clear, the block SHALL set code <= INIT_CODE, count <= 0, code_ready <= 0 and err <= 0.
REQ-021 clear SHALL take priority over key_valid and key_back in the same cycle.
REQ-022 Outputs SHALL change only on the clock edge, with latency 1 cycle from strobe to output, and no combinational input-to-output paths.
REQ-023 err SHALL stay set until clear or rst.
REQ-024 Held strobes (high for several cycles) SHALL act once per cycle they are high.

Reset
REQ-025 While rst is high at a rising clk, the block SHALL set code = INIT_CODE, count = 0, code_ready = 0 and err = 0.
REQ-026 rst SHALL take priority over all other inputs, including mid-entry.
REQ-027 Outputs SHALL be undefined before the first reset edge; the bench SHALL apply rst for at least 1 cycle.

Verification
REQ-028 Reset, then key_valid with 1, 2, 3, 4 on four cycles -> code=16'h1234, count=4, code_ready=1 one cycle after the 4th strobe.
REQ-029 Fill with A, B, C, D, then key_valid 5 -> code remains 16'hABCD and err=1; then clear -> code=INIT_CODE, count=0, err=0.
REQ-030 Enter 1, 2, 3, then key_back, then 9, 8 -> code=16'h1298, code_ready=1.
REQ-031 key_back in EMPTY -> count=0 and err=1; key_valid together with key_back at count 2 -> count=1 and err unchanged.
REQ-032 Instance with INIT_CODE=16'hFFFF and rst asserted after 2 entries -> code=16'hFFFF, count=0, code_ready=0.
REQ-033 Two instances loaded with identical digit sequences -> bitwise-equal code words; one differing digit -> the words differ in exactly that nibble.
